// File: rtl/isfet_sample_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : isfet_sample_packer
// Description : Packs LANES consecutive SAMPLE_W-bit ISFET samples into one
//               word for the readout FIFO. A start-of-frame flushes any
//               partial word zero-padded. Optional frame header words are
//               enabled by the macro ISFET_PACKER_HEADER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module isfet_sample_packer #(
    parameter int SAMPLE_W = 16,
    parameter int LANES    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    input  logic [SAMPLE_W-1:0]         s_data,
    input  logic                        s_sof,
    output logic                        s_ready,
    input  logic                        fifo_rdy,
    input  logic                        fifo_full,
    output logic [SAMPLE_W*LANES-1:0]   fifo_din,
    output logic                        fifo_wr_en,
    output logic [15:0]                 frame_cnt
);

    localparam int c_OUT_W = SAMPLE_W * LANES;
    localparam int c_CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(LANES - 1);

    typedef enum logic [0:0] {
        ST_WAIT_RDY = 1'b0,
        ST_RUN      = 1'b1
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_OUT_W-1:0]   r_pack;
    logic [c_OUT_W-1:0]   r_out;
    logic                 r_out_vld;
    logic [15:0]          r_frame_cnt;

    logic                 w_run;
    logic                 w_wr_en;
    logic                 w_slot_free;
    logic                 w_last;
    logic                 w_flush_pend;
    logic                 w_flush;
    logic                 w_hdr_pend;
    logic                 w_hdr_load;
    logic                 w_stall;
    logic                 w_ready;
    logic                 w_accept;
    logic [c_OUT_W-1:0]   w_pack_next;

    assign w_run        = (r_state == ST_RUN);
    assign w_wr_en      = r_out_vld && !fifo_full;
    // The output register can take a new word when it is empty or being drained now
    assign w_slot_free  = !r_out_vld || w_wr_en;
    assign w_last       = (r_cnt == c_LAST);
    assign w_flush_pend = s_valid && s_sof && (r_cnt != '0);
    assign w_flush      = w_run && w_flush_pend && w_slot_free;

`ifdef ISFET_PACKER_HEADER_EN
    logic                 r_hdr_done;
    logic [c_OUT_W-1:0]   w_hdr_word;

    assign w_hdr_pend = s_valid && s_sof && !r_hdr_done;
    // Header follows any flush, so it only loads once the pack register is empty
    assign w_hdr_load = w_run && w_hdr_pend && !w_flush_pend && w_slot_free;

    always_comb begin
        w_hdr_word = '0;
        w_hdr_word[(LANES-1)*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(16'hA5A5);
        w_hdr_word[0 +: SAMPLE_W] = SAMPLE_W'(r_frame_cnt + 16'd1);
    end
`else
    assign w_hdr_pend = 1'b0;
    assign w_hdr_load = 1'b0;
`endif

    assign w_stall  = (w_last && !w_slot_free) || w_flush_pend || w_hdr_pend;
    assign w_ready  = w_run && !w_stall;
    assign w_accept = s_valid && w_ready;

    always_comb begin
        w_pack_next = r_pack;
        w_pack_next[int'(r_cnt)*SAMPLE_W +: SAMPLE_W] = s_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_WAIT_RDY;
            r_cnt       <= '0;
            r_pack      <= '0;
            r_out       <= '0;
            r_out_vld   <= 1'b0;
            r_frame_cnt <= 16'd0;
`ifdef ISFET_PACKER_HEADER_EN
            r_hdr_done  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_WAIT_RDY: if (fifo_rdy) r_state <= ST_RUN;
                ST_RUN:      r_state <= ST_RUN;
                default:     r_state <= ST_WAIT_RDY;
            endcase

            if (w_wr_en) begin
                r_out_vld <= 1'b0;
            end

            if (w_flush) begin
                r_out     <= r_pack;
                r_out_vld <= 1'b1;
                r_pack    <= '0;
                r_cnt     <= '0;
`ifdef ISFET_PACKER_HEADER_EN
            end else if (w_hdr_load) begin
                r_out      <= w_hdr_word;
                r_out_vld  <= 1'b1;
                r_hdr_done <= 1'b1;
`endif
            end else if (w_accept) begin
                if (w_last) begin
                    r_out     <= w_pack_next;
                    r_out_vld <= 1'b1;
                    r_pack    <= '0;
                    r_cnt     <= '0;
                end else begin
                    r_pack    <= w_pack_next;
                    r_cnt     <= r_cnt + c_CNT_W'(1);
                end
                if (s_sof) begin
                    r_frame_cnt <= r_frame_cnt + 16'd1;
`ifdef ISFET_PACKER_HEADER_EN
                    r_hdr_done  <= 1'b0;
`endif
                end
            end
        end
    end

    assign s_ready    = w_ready;
    assign fifo_wr_en = w_wr_en;
    assign fifo_din   = r_out;
    assign frame_cnt  = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_isfet_sample_packer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_isfet_sample_packer
// Description : Directed self-checking bench for isfet_sample_packer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_isfet_sample_packer;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_valid = 1'b0;
    logic [15:0]  s_data = 16'd0;
    logic         s_sof = 1'b0;
    logic         s_ready;
    logic         fifo_rdy = 1'b0;
    logic         fifo_full = 1'b0;
    logic [255:0] fifo_din;
    logic         fifo_wr_en;
    logic [15:0]  frame_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [255:0] wq[$];
    int           wc[$];

    isfet_sample_packer #(.SAMPLE_W(16), .LANES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_sof      (s_sof),
        .s_ready    (s_ready),
        .fifo_rdy   (fifo_rdy),
        .fifo_full  (fifo_full),
        .fifo_din   (fifo_din),
        .fifo_wr_en (fifo_wr_en),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Capture every FIFO write just before the edge that performs it
    always begin
        @(negedge clk);
        #4;
        if (fifo_wr_en === 1'b1) begin
            wq.push_back(fifo_din);
            wc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else
            n_pass++;
    endtask

    function automatic logic [255:0] seq_word(input logic [15:0] base);
        logic [255:0] w;
        for (int i = 0; i < 16; i++) w[i*16 +: 16] = base + 16'(i);
        return w;
    endfunction

    function automatic logic [255:0] hdr_word(input logic [15:0] n);
        logic [255:0] w;
        w = '0;
        w[15:0]    = n;
        w[255:240] = 16'hA5A5;
        return w;
    endfunction

    task automatic send(input logic [15:0] d, input logic sof, output int acc);
        int t;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        #4;
        t = 0;
        while (s_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            #4;
            t++;
        end
        if (s_ready !== 1'b1) check("send_timeout", {255'd0, s_ready}, 256'd1);
        acc = cyc;
    endtask

    task automatic idle();
        @(negedge clk);
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [255:0] exp, output int wcyc);
        int t;
        t = 0;
        while (wq.size() == 0 && t < 60) begin
            @(posedge clk);
            #1;
            t++;
        end
        check({tag, "_seen"}, 256'(wq.size() != 0), 256'd1);
        wcyc = -1;
        if (wq.size() != 0) begin
            check(tag, wq.pop_front(), exp);
            wcyc = wc.pop_front();
        end
    endtask

    initial begin
        int acc[1:32];
        int a5, asof, wcyc, dummy;
        logic seen_rdy;
        logic [255:0] exp_w;

        // Reset values
        @(negedge clk);
        #4;
        check("rst_s_ready", 256'(s_ready), 256'd0);
        check("rst_wr_en",   256'(fifo_wr_en), 256'd0);
        check("rst_din",     fifo_din, 256'd0);
        check("rst_frame",   256'(frame_cnt), 256'd0);

        // Held in WAIT_RDY while fifo_rdy is low
        @(negedge clk);
        rst = 1'b0;
        s_valid = 1'b1;
        s_data = 16'd1;
        seen_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #4;
            seen_rdy |= s_ready;
        end
        check("wait_rdy_s_ready", 256'(seen_rdy), 256'd0);
        @(posedge clk);
        #1;
        check("wait_rdy_no_write", 256'(wq.size()), 256'd0);
        @(negedge clk);
        fifo_rdy = 1'b1;

        // Stream 1..32 with the FIFO open
        for (int i = 1; i <= 32; i++) send(16'(i), 1'b0, acc[i]);
        idle();
        expect_word("stream_w0", seq_word(16'h0001), wcyc);
        check("latency", 256'(wcyc), 256'(acc[16] + 1));
        expect_word("stream_w1", seq_word(16'h0011), dummy);
        check("throughput", 256'(acc[32] - acc[1]), 256'd31);

        // FIFO full: one word held, stall at lane 15, then drain in order
        @(negedge clk);
        fifo_full = 1'b1;
        for (int i = 1; i <= 31; i++) send(16'h0100 + 16'(i), 1'b0, dummy);
        @(negedge clk);
        s_data = 16'h0120;
        #4;
        check("full_stall", 256'(s_ready), 256'd0);
        check("full_no_wr", 256'(fifo_wr_en), 256'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #4;
            check("full_din_hold", fifo_din, seq_word(16'h0101));
        end
        @(posedge clk);
        #1;
        check("full_no_write", 256'(wq.size()), 256'd0);
        @(negedge clk);
        fifo_full = 1'b0;
        #4;
        check("full_release_ready", 256'(s_ready), 256'd1);
        idle();
        expect_word("full_w0", seq_word(16'h0101), dummy);
        expect_word("full_w1", seq_word(16'h0111), dummy);

        // SOF flush of a 5-sample partial word
        for (int i = 1; i <= 5; i++) send(16'h0200 + 16'(i), 1'b0, a5);
        check("frame_before_sof", 256'(frame_cnt), 256'd0);
        send(16'hBEEF, 1'b1, asof);
        check("sof_stall", 256'((asof - a5) >= 2), 256'd1);
        for (int i = 2; i <= 16; i++) send(16'h0300 + 16'(i), 1'b0, dummy);
        idle();
        exp_w = '0;
        for (int i = 0; i < 5; i++) exp_w[i*16 +: 16] = 16'h0201 + 16'(i);
        expect_word("flush_word", exp_w, dummy);
`ifdef ISFET_PACKER_HEADER_EN
        expect_word("flush_hdr", hdr_word(16'd1), dummy);
`endif
        exp_w = seq_word(16'h0301);
        exp_w[15:0] = 16'hBEEF;
        expect_word("sof_word", exp_w, dummy);
        check("frame_after_sof", 256'(frame_cnt), 256'd1);

        // Reset with a 7-sample partial word
        for (int i = 1; i <= 7; i++) send(16'h0400 + 16'(i), 1'b0, dummy);
        @(negedge clk);
        s_valid = 1'b0;
        rst = 1'b1;
        fifo_rdy = 1'b0;
        #4;
        check("mid_rst_s_ready", 256'(s_ready), 256'd0);
        check("mid_rst_wr_en",   256'(fifo_wr_en), 256'd0);
        check("mid_rst_din",     fifo_din, 256'd0);
        check("mid_rst_frame",   256'(frame_cnt), 256'd0);
        @(negedge clk);
        rst = 1'b0;
        s_valid = 1'b1;
        s_data = 16'h0500;
        s_sof = 1'b1;
        seen_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #4;
            seen_rdy |= s_ready;
        end
        check("post_rst_wait", 256'(seen_rdy), 256'd0);
        @(posedge clk);
        #1;
        check("post_rst_no_write", 256'(wq.size()), 256'd0);
        @(negedge clk);
        fifo_rdy = 1'b1;

        // Three SOF frames of 16 samples
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < 16; i++)
                send(16'h0500 + 16'(f*16 + i), (i == 0), dummy);
        idle();
        for (int f = 0; f < 3; f++) begin
`ifdef ISFET_PACKER_HEADER_EN
            expect_word("frame_hdr", hdr_word(16'(f + 1)), dummy);
`endif
            expect_word("frame_data", seq_word(16'h0500 + 16'(f*16)), dummy);
        end
        check("frame_cnt_3", 256'(frame_cnt), 256'd3);
        repeat (4) @(posedge clk);
        #1;
        check("no_extra_writes", 256'(wq.size()), 256'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
